// File: rtl/relu_rr_sched.sv
// relu_rr_sched: round-robin scheduler sharing one single-cycle relu stage
// among N_CH convolution output channels for one layer pass.
//
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_start, i_len            start pulse (IDLE only) and results per channel
//   i_valid, i_data           per-channel sample requests, channel k at [k*DW +: DW]
//   o_ready                   combinational one-hot grant
//   o_relu_en, o_relu_data    registered feed to the shared relu stage
//   i_relu_en, i_relu_data    relu stage return (fixed 1-cycle latency)
//   o_en, o_data, o_ch        registered activation result with channel tag
//   o_busy                    high while in RUN or DRAIN
//   o_done                    single-cycle pulse at the end of a pass

`ifndef DW
`define DW 16
`endif

module relu_rr_sched #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned DW   = `DW,
  parameter int unsigned CW   = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [CW-1:0]             i_len,
  input  logic [N_CH-1:0]           i_valid,
  input  logic [N_CH*DW-1:0]        i_data,
  output logic [N_CH-1:0]           o_ready,
  output logic                      o_relu_en,
  output logic [DW-1:0]             o_relu_data,
  input  logic                      i_relu_en,
  input  logic [DW-1:0]             i_relu_data,
  output logic                      o_en,
  output logic [DW-1:0]             o_data,
  output logic [$clog2(N_CH)-1:0]   o_ch,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int unsigned CHW = $clog2(N_CH);
  localparam int unsigned EW  = CW + CHW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   len;
  logic [CW-1:0]   issued [N_CH];
  logic [EW-1:0]   emitted;
  logic [EW-1:0]   total;
  logic [CHW-1:0]  ptr;
  logic [CHW-1:0]  ptr_nxt;
  logic [CHW-1:0]  tag1;
  logic [CHW-1:0]  tag2;
  logic [CHW-1:0]  gnt_idx;
  logic            gnt_vld;
  logic [DW-1:0]   gnt_data;
  logic [N_CH-1:0] elig;
  logic            all_issued;
  logic            busy_now;
  logic            start_ok;

  assign busy_now = (state == RUN) || (state == DRAIN);
  assign start_ok = (state == IDLE) && i_start;
  // Cannot overflow: N_CH <= 2**CHW, so N_CH*len fits in CW+CHW bits.
  assign total    = EW'(len) * EW'(N_CH);

  // Per-channel eligibility and pass-complete detection
  always_comb begin
    elig       = '0;
    all_issued = 1'b1;
    for (int unsigned k = 0; k < N_CH; k++) begin
      elig[k] = i_valid[k] && (issued[k] < len);
      if (issued[k] != len) all_issued = 1'b0;
    end
  end

  // Round-robin search starting at ptr, wrapping N_CH-1 -> 0
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (state == RUN) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        idx = (32'(ptr) + i) % N_CH;
        if (!gnt_vld && elig[CHW'(idx)]) begin
          gnt_vld = 1'b1;
          gnt_idx = CHW'(idx);
        end
      end
    end
  end

  // Grant vector and selected sample
  always_comb begin
    o_ready  = '0;
    gnt_data = '0;
    if (gnt_vld) o_ready[gnt_idx] = 1'b1;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (gnt_idx == CHW'(k)) gnt_data = i_data[k*DW +: DW];
    end
  end

  assign ptr_nxt = (gnt_idx == CHW'(N_CH - 1)) ? '0 : gnt_idx + CHW'(1);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = (i_len == '0) ? DONE : RUN;
      RUN:     if (all_issued) state_nxt = DRAIN;
      DRAIN:   if (emitted == total) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Pass bookkeeping: length, per-channel issue counts, pointer, emitted count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      len     <= '0;
      emitted <= '0;
      ptr     <= '0;
      for (int unsigned k = 0; k < N_CH; k++) issued[k] <= '0;
    end else if (start_ok) begin
      len     <= i_len;
      emitted <= '0;
      ptr     <= '0;
      for (int unsigned k = 0; k < N_CH; k++) issued[k] <= '0;
    end else begin
      if (gnt_vld) begin
        ptr             <= ptr_nxt;
        issued[gnt_idx] <= issued[gnt_idx] + CW'(1);
      end
      if (busy_now && i_relu_en) emitted <= emitted + EW'(1);
    end
  end

  // relu feed and the two-stage tag pipeline matching the relu latency
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_relu_en   <= 1'b0;
      o_relu_data <= '0;
      tag1        <= '0;
      tag2        <= '0;
    end else begin
      o_relu_en   <= gnt_vld;
      o_relu_data <= gnt_vld ? gnt_data : '0;
      if (gnt_vld) tag1 <= gnt_idx;
      tag2        <= tag1;
    end
  end

  // Output stage; returns outside a pass (e.g. after an abort) are dropped
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_en   <= 1'b0;
      o_data <= '0;
      o_ch   <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_en   <= i_relu_en && busy_now;
      o_data <= i_relu_data;
      o_ch   <= tag2;
      o_busy <= (state_nxt == RUN) || (state_nxt == DRAIN);
      o_done <= (state_nxt == DONE);
    end
  end

endmodule

// File: doc/relu_rr_sched.md
# relu_rr_sched

Round-robin scheduler that shares one `relu` stage among N_CH convolution output channels for one layer pass. Each cycle it grants at most one valid channel, drives the shared `relu` with that channel's sample and carries the channel index alongside the one-cycle `relu` latency. It counts per-channel and total results and signals completion when every channel has produced `i_len` activations. It sits between the DSP-cascade channel outputs and the activation write-back.

## Interface
- `N_CH`, default 4: number of requesting channels, ≥2.
- `DW`, default `` `DW ``: sample width, signed.
- `CW`, default 16: width of the per-channel length and counters.
- `CHW`, localparam `$clog2(N_CH)`: channel tag width.

Ports:
- `i_clk`  in  1  the only clock; all state changes on its rising edge.
- `i_rst`  in  1  reset, asynchronous and active-high.
- `i_start`  in  1  single-cycle pulse; latches `i_len` and starts a pass. Honoured in IDLE only.
- `i_len`  in  CW  results per channel for this pass.
- `i_valid`  in  N_CH  channel k has a sample pending.
- `i_data`  in  N_CH*DW  channel k's sample is at `[k*DW +: DW]`.
- `o_ready`  out  N_CH  combinational one-hot grant; the sample transfers when `i_valid[k] & o_ready[k]`.
- `o_relu_en`, `o_relu_data`  out  1, DW  registered feed to `relu` `i_en`/`i_data`.
- `i_relu_en`, `i_relu_data`  in  1, DW  return from `relu` `o_en`/`o_data`.
- `o_en`, `o_data`, `o_ch`  out  1, DW, CHW  registered activation result with its channel tag.
- `o_busy`  out  1  high in RUN and DRAIN.
- `o_done`  out  1  single-cycle pulse at the end of a pass.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE. Reset enters IDLE.
- IDLE to RUN on `i_start`. The block latches `len = i_len` and clears `issued[k]`, `emitted` and the pointer `ptr`.
- If `i_len == 0`, IDLE goes to DONE directly; no grants are issued.
- Eligibility in RUN: channel k is eligible when `i_valid[k] && issued[k] < len`.
- Arbitration is round-robin. The block grants the first eligible channel found searching from `ptr` upward, wrapping from N_CH-1 to 0.
- On a grant to channel g:
  - `ptr <= (g+1) mod N_CH`;
  - `issued[g]++`;
  - `o_relu_en <= 1`, `o_relu_data <= sample`, `tag1 <= g`.
- With no eligible channel: `o_ready = 0`, `o_relu_en <= 0`, `o_relu_data <= 0`, and `ptr` holds.
- `o_ready` is all-zero outside RUN.
- Tag alignment: `tag2 <= tag1` every cycle. The output stage registers `o_en <= i_relu_en`, `o_data <= i_relu_data` and `o_ch <= tag2`.
- `emitted` increments on each `i_relu_en`.
- RUN to DRAIN in the cycle after all `issued[k] == len`.
- DRAIN to DONE when `emitted == N_CH*len`. The comparison is `CW+CHW` bits wide, with no overflow.
- DONE lasts one cycle with `o_done = 1`, then returns to IDLE.
- `i_start` outside IDLE is ignored and `len` is unchanged.
- The `relu` stage is required to have a fixed latency of 1 cycle. Output ordering equals grant ordering.

## Timing
- Reset values: all outputs are 0. `ptr`, `tag1`, `tag2`, the counters and `len` are 0, and the state is IDLE.
- Asynchronous `i_rst` mid-pass aborts immediately. In-flight samples are discarded, and `o_en` is not asserted for them after reset is released.
- Latency: a sample accepted at edge t appears on `o_relu_en` after t, on `relu` `o_en` after t+1, and on `o_en`/`o_ch` after t+2. That is 3 cycles from acceptance to output.
- Throughput is 1 sample per cycle when any channel is eligible.
- Fairness: with all channels continuously valid, grants cycle 0,1,…,N_CH-1,0,… and no channel waits more than N_CH-1 cycles.
- A channel that has reached `len` is skipped without a stall cycle, even if it is still valid.
- `o_busy` is high in RUN and DRAIN only.
- `o_done` rises exactly one cycle after the last `o_en` of the pass.
- Simultaneous events: a grant and `i_relu_en` in the same cycle both take effect.
- `i_start` on the DONE cycle is ignored; it is accepted in IDLE only.

## Test plan
- **Round-robin with all valid:** N_CH=4, `i_len`=3, all `i_valid` high, channel k sends `k*10+n`. Required: `o_ch` sequence is 0,1,2,3 repeated 3 times, with 12 consecutive `o_en`. `o_done` is high 1 cycle after the last `o_en`.
- **ReLU sign handling:** channel 1 sends -5, then 7, with `i_len`=2 and only channel 1 valid. Required: `o_data` is 0 then 7, with `o_ch`=1, 3 cycles after each accept. The pass waits in RUN for the other channels.
- **Uneven availability:** channel 2 valid every cycle, the others valid every 4th cycle, `i_len`=2. Required: channel 2 is granted exactly twice, then skipped while still valid. Total `o_en` count is 8.
- **Zero length:** `i_start` with `i_len`=0. Required: IDLE→DONE→IDLE, `o_done` pulses on the 2nd cycle, and `o_ready`, `o_relu_en` and `o_en` are never asserted.
- **Reset mid-pass:** assert `i_rst` 2 cycles after the first grant. Required: all outputs read 0 immediately with no trailing `o_en`. A new `i_start` with `i_len`=1 completes normally with 4 outputs.
- **Start ignored while busy:** pulse `i_start` with `i_len`=9 during RUN. Required: the original `len` is used and `o_done` asserts exactly once.
